// File: rtl/ldvio_pkg.sv
// Shared types and counter helpers for the set-associative load-violation predictor.
// Entry fields are sized to the largest supported widths; narrower instances leave upper bits at zero.
package ldvio_pkg;

  localparam int TAG_W_MAX = 32;
  localparam int CNT_W_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [CNT_W_MAX-1:0] cnt;
  } ldvio_entry_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } ldvio_age_state_t;

  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] cnt,
                                                   input logic [CNT_W_MAX-1:0] max);
    sat_inc = (cnt >= max) ? cnt : cnt + CNT_W_MAX'(1);
  endfunction

  function automatic logic [CNT_W_MAX-1:0] sat_dec(input logic [CNT_W_MAX-1:0] cnt);
    sat_dec = (cnt == {CNT_W_MAX{1'b0}}) ? {CNT_W_MAX{1'b0}} : cnt - CNT_W_MAX'(1);
  endfunction

endpackage

// File: rtl/ldvio_chk.sv
// Per-set checker: a training lookup may match at most one way, since allocation only happens on a miss.
module ldvio_chk #(
  parameter int WAYS = 2
) (
  input logic            clk,
  input logic            reset,
  input logic [WAYS-1:0] hit_i
);

  a_no_multi_hit: assert property (@(posedge clk) disable iff (reset) $onehot0(hit_i));

endmodule

// File: rtl/ldvio_set_ctl.sv
// Next-state logic for one predictor set: training hit/allocate/replace merged with the decay sweep.
// When training and decay land on the same set, the trained way takes the training result.
module ldvio_set_ctl
  import ldvio_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int RR_W   = 1,
  parameter int TAG_W  = 10,
  parameter int CNT_W  = 2,
  parameter int THRESH = 2
) (
  input  ldvio_entry_t [WAYS-1:0] ent_i,
  input  logic [RR_W-1:0]         rr_i,
  input  logic                    train_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic                    decay_i,
  output ldvio_entry_t [WAYS-1:0] ent_o,
  output logic [RR_W-1:0]         rr_o,
  output logic [WAYS-1:0]         hit_o
);

  localparam logic [CNT_W_MAX-1:0] CNT_MAX = CNT_W_MAX'((1 << CNT_W) - 1);
  localparam logic [CNT_W_MAX-1:0] THR     = CNT_W_MAX'(THRESH);

  logic [TAG_W_MAX-1:0] tag_ext_s;
  logic [WAYS-1:0]      hit_s;
  logic                 hit_any_s;
  logic                 inv_any_s;
  logic [RR_W-1:0]      hit_idx_s;
  logic [RR_W-1:0]      inv_idx_s;
  logic [RR_W-1:0]      tgt_s;

  assign tag_ext_s = TAG_W_MAX'(tag_i);
  assign hit_any_s = |hit_s;
  assign hit_o     = hit_s & {WAYS{train_i}};

  // Descending scan so the lowest matching / invalid index wins.
  always_comb begin
    hit_s     = {WAYS{1'b0}};
    hit_idx_s = {RR_W{1'b0}};
    inv_any_s = 1'b0;
    inv_idx_s = {RR_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_s[w]  = ent_i[w].valid && (ent_i[w].tag == tag_ext_s);
      hit_idx_s = hit_s[w] ? RR_W'(w) : hit_idx_s;
      inv_idx_s = !ent_i[w].valid ? RR_W'(w) : inv_idx_s;
      inv_any_s = inv_any_s | !ent_i[w].valid;
    end
  end

  assign tgt_s = hit_any_s ? hit_idx_s : (inv_any_s ? inv_idx_s : rr_i);

  always_comb begin
    ent_o = ent_i;
    for (int w = 0; w < WAYS; w++) begin
      if (train_i && (tgt_s == RR_W'(w))) begin
        ent_o[w].valid = 1'b1;
        ent_o[w].tag   = tag_ext_s;
        ent_o[w].cnt   = hit_any_s ? sat_inc(ent_i[w].cnt, CNT_MAX) : THR;
      end else if (decay_i && ent_i[w].valid && (ent_i[w].cnt != {CNT_W_MAX{1'b0}})) begin
        ent_o[w].valid = (ent_i[w].cnt != CNT_W_MAX'(1));
        ent_o[w].tag   = ent_i[w].tag;
        ent_o[w].cnt   = sat_dec(ent_i[w].cnt);
      end else begin
        ent_o[w] = ent_i[w];
      end
    end
  end

  // Victim pointer only advances when a full set is forced to replace.
  always_comb begin
    if (train_i && !hit_any_s && !inv_any_s) begin
      rr_o = (rr_i == RR_W'(WAYS - 1)) ? {RR_W{1'b0}} : rr_i + RR_W'(1);
    end else begin
      rr_o = rr_i;
    end
  end

endmodule

// File: rtl/ld_vio_pred_assoc.sv
// Set-associative load-violation predictor: table storage, dispatch lookup,
// training from load-violation recoveries, and a periodic set-by-set confidence decay sweep.
module ld_vio_pred_assoc
  import ldvio_pkg::*;
#(
  parameter int DISPATCH_WIDTH = 4,
  parameter int PC_W           = 32,
  parameter int INST_OFF       = 2,
  parameter int SETS_LOG       = 6,
  parameter int WAYS           = 2,
  parameter int TAG_W          = 10,
  parameter int CNT_W          = 2,
  parameter int THRESH         = 2,
  parameter int AGE_LOG        = 14
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DISPATCH_WIDTH*PC_W-1:0] pc_i,
  input  logic [DISPATCH_WIDTH-1:0]      isLoad_i,
  output logic [DISPATCH_WIDTH-1:0]      predLoadVio_o,
  input  logic                           loadViolation_i,
  input  logic                           recoverFlag_i,
  input  logic [PC_W-1:0]                recoverPC_i,
  output logic                           ageBusy_o
);

  localparam int SETS = 1 << SETS_LOG;
  localparam int RR_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W_MAX-1:0] THR = CNT_W_MAX'(THRESH);

  ldvio_entry_t [WAYS-1:0] tbl_q [SETS];
  ldvio_entry_t [WAYS-1:0] tbl_d [SETS];
  logic [RR_W-1:0]         rr_q  [SETS];
  logic [RR_W-1:0]         rr_d  [SETS];

  ldvio_age_state_t     state_q, state_d;
  logic [AGE_LOG-1:0]   age_cnt_q;
  logic [SETS_LOG-1:0]  ptr_q, ptr_d;

  logic                      train_s;
  logic [SETS_LOG-1:0]       train_set_s;
  logic [TAG_W-1:0]          train_tag_s;
  logic [DISPATCH_WIDTH-1:0] match_s;
  logic                      unused_pc_s;

  assign train_s     = loadViolation_i & recoverFlag_i;
  assign train_set_s = recoverPC_i[INST_OFF +: SETS_LOG];
  assign train_tag_s = recoverPC_i[INST_OFF+SETS_LOG +: TAG_W];
  assign unused_pc_s = ^{pc_i, recoverPC_i};

  // Lookup reads the registered table, so a same-cycle training update is not visible.
  always_comb begin
    match_s = {DISPATCH_WIDTH{1'b0}};
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      for (int w = 0; w < WAYS; w++) begin
        match_s[i] = match_s[i] |
          (tbl_q[pc_i[i*PC_W+INST_OFF +: SETS_LOG]][w].valid &&
           (tbl_q[pc_i[i*PC_W+INST_OFF +: SETS_LOG]][w].tag ==
            TAG_W_MAX'(pc_i[i*PC_W+INST_OFF+SETS_LOG +: TAG_W])) &&
           (tbl_q[pc_i[i*PC_W+INST_OFF +: SETS_LOG]][w].cnt >= THR));
      end
    end
  end

  assign predLoadVio_o = isLoad_i & match_s;
  assign ageBusy_o     = (state_q == SWEEP);

  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic [WAYS-1:0] hit_s;

    ldvio_set_ctl #(
      .WAYS   (WAYS),
      .RR_W   (RR_W),
      .TAG_W  (TAG_W),
      .CNT_W  (CNT_W),
      .THRESH (THRESH)
    ) u_set_ctl (
      .ent_i   (tbl_q[s]),
      .rr_i    (rr_q[s]),
      .train_i (train_s && (train_set_s == SETS_LOG'(s))),
      .tag_i   (train_tag_s),
      .decay_i ((state_q == SWEEP) && (ptr_q == SETS_LOG'(s))),
      .ent_o   (tbl_d[s]),
      .rr_o    (rr_d[s]),
      .hit_o   (hit_s)
    );

    ldvio_chk #(.WAYS(WAYS)) u_chk (
      .clk   (clk),
      .reset (reset),
      .hit_i (hit_s)
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        tbl_q[s] <= '0;
        rr_q[s]  <= {RR_W{1'b0}};
      end
    end else begin
      for (int s = 0; s < SETS; s++) begin
        tbl_q[s] <= tbl_d[s];
        rr_q[s]  <= rr_d[s];
      end
    end
  end

  // A period wrap while already sweeping is ignored; the sweep only arms from IDLE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (&age_cnt_q) begin
          state_d = SWEEP;
          ptr_d   = {SETS_LOG{1'b0}};
        end else begin
          state_d = IDLE;
          ptr_d   = ptr_q;
        end
      end
      SWEEP: begin
        ptr_d   = ptr_q + SETS_LOG'(1);
        state_d = (&ptr_q) ? IDLE : SWEEP;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = {SETS_LOG{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= {SETS_LOG{1'b0}};
      age_cnt_q <= {AGE_LOG{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      age_cnt_q <= age_cnt_q + AGE_LOG'(1);
    end
  end

endmodule
